dqpsk_demodulator: RTL and testbench
====================================

Name: dqpsk_demodulator

Overview:
- Receive-side counterpart of the DQPSK modulator.
- Takes the recovered absolute phase index (0..3) per symbol and differentially decodes it back to dibits: dibit = (phase_now - phase_prev) mod 4.
- Hunts for a sync word in the dibit stream, then packs payload dibits MSB-first into bytes for a fixed-length frame.
- Sits between the phase slicer and the packet/byte sink.

Parameters:
SYNC_WORD, 16'hE4E4, 8-dibit sync pattern; first-received dibit ends in bits [15:14], last in [1:0]
PAYLOAD_BYTES, 16, bytes delivered per frame after sync (1..255)
GAP_MAX, 255, consecutive idle cycles (phase_valid=0) tolerated before abort (1..255)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
phase_in  input  2  received phase index, qualified by phase_valid
phase_valid  input  1  one symbol sampled per cycle where high
byte_out  output  8  assembled payload byte, valid when byte_valid=1
byte_valid  output  1  one-cycle pulse per payload byte
frame_start  output  1  one-cycle pulse when sync word matched
frame_done  output  1  one-cycle pulse with the last payload byte
frame_error  output  1  one-cycle pulse on gap timeout during PAYLOAD
locked  output  1  high while in PAYLOAD

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; prev_phase=0; sync shift=0; dibit/byte counters=0; gap counter=0. Outputs: byte_out=0, byte_valid=0, frame_start=0, frame_done=0, frame_error=0, locked=0. A reset asserted mid-frame discards everything.
- All outputs are registered. A pulse is set at the clock edge that samples the causing symbol and is visible for exactly one cycle. byte_out holds its last value between pulses.
- Differential decode: dibit = (phase_in - prev_phase) mod 4, 2-bit wraparound subtraction. prev_phase <= phase_in on every sampled symbol in HUNT or PAYLOAD.

State IDLE:
- The first symbol with phase_valid=1 is the phase reference only: it loads prev_phase, produces no dibit, and moves the block to HUNT.
- Sync shift and sync count are cleared on entry.

State HUNT:
- Each dibit shifts into the LSBs of a 16-bit register (shift <= {shift[13:0], dibit}).
- A 4-bit count saturates at 8.
- Match when count>=8 (including the current dibit) and the new shift value == SYNC_WORD.
- On match: frame_start=1, go to PAYLOAD, clear the byte assembler and byte count.

State PAYLOAD:
- Dibits pack MSB-first: the 1st dibit goes to [7:6], the 4th to [1:0].
- On the 4th dibit: byte_out=assembled byte, byte_valid=1, byte count++.
- When byte count reaches PAYLOAD_BYTES: frame_done=1 in the same cycle as that byte_valid, locked drops, go to HUNT.
- prev_phase is retained, so no new reference is needed. Sync shift and count are cleared.

Gap timeout:
- The gap counter increments on each cycle with phase_valid=0 in HUNT/PAYLOAD and clears on phase_valid=1.
- When it reaches GAP_MAX, go to IDLE at that edge, so the next symbol is a new reference.
- If the timeout occurs in PAYLOAD, frame_error=1 and the partial byte and frame are discarded. A timeout in HUNT is silent.
- No timeout in IDLE.

Other rules:
- Sync detection is disabled during PAYLOAD; a payload containing the sync word is not re-synced.
- locked = (state==PAYLOAD), registered.
- frame_start and byte_valid are never set on the same edge.
- Byte count is 8 bits; the dibit-in-byte index is 2 bits and wraps 3->0.

Test Plan:
- Decode/sync: after reset, phases 0,3,1,2,2,1,3,0,0 (dibits 3,2,1,0,3,2,1,0) -> frame_start pulse on the 9th symbol's edge, locked=1 next cycle. Then phases 1,3,3,2 (dibits 1,2,0,3) -> byte_valid with byte_out=0x63.
- Wraparound: in PAYLOAD, phases cycle 3,0,1,2 from prev=2 (dibits 1,1,1,1) -> byte_out=0x55. Constant phase for 4 symbols -> byte_out=0x00.
- Full frame, PAYLOAD_BYTES=2: sync then 8 payload symbols -> two byte_valid pulses; frame_done coincides with the second; locked falls; the next sync word without a new reference symbol -> frame_start again.
- Gap abort, GAP_MAX=4: in PAYLOAD after 2 dibits, hold phase_valid=0 for 4 cycles -> frame_error pulse on the 4th idle edge, state IDLE, locked=0, no byte_valid. The next symbol produces no dibit (reference).
- Partial/false sync: 7 matching dibits then a wrong one -> no frame_start. Sync embedded in payload -> no frame_start, bytes delivered normally.
- Async reset mid-PAYLOAD: assert reset between edges -> all outputs 0 immediately. After release, the first symbol is a reference and the block hunts again.

Source files
------------

// File: rtl/dqpsk_demodulator.sv
// DQPSK receive back end: differential phase decode, sync-word hunt and
// MSB-first byte packing of a fixed-length payload frame.
module dqpsk_demodulator #(
  parameter logic [15:0] SYNC_WORD     = 16'hE4E4,
  parameter int          PAYLOAD_BYTES = 16,
  parameter int          GAP_MAX       = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] phase_in,
  input  logic       phase_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_error,
  output logic       locked,
  output logic [1:0] dbg_state
);

  // Handshake: phase_in is consumed on every rising edge where phase_valid=1;
  // there is no back-pressure. Output pulses are one-cycle, registered strobes.

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HUNT    = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  localparam logic [7:0] LP_PAYLOAD_BYTES = 8'(PAYLOAD_BYTES);
  localparam logic [7:0] LP_GAP_MAX       = 8'(GAP_MAX);

  logic [1:0]  r_state;
  logic [1:0]  r_prev_phase;
  logic [15:0] r_shift;
  logic [3:0]  r_sync_cnt;
  logic [5:0]  r_byte_asm;
  logic [1:0]  r_dibit_idx;
  logic [7:0]  r_byte_cnt;
  logic [7:0]  r_gap_cnt;
  logic [7:0]  r_byte_out;
  logic        r_byte_valid;
  logic        r_frame_start;
  logic        r_frame_done;
  logic        r_frame_error;
  logic        r_locked;

  logic [1:0]  w_dibit;
  logic [15:0] w_shift_nxt;
  logic [3:0]  w_sync_cnt_nxt;
  logic        w_sync_match;
  logic [7:0]  w_byte_nxt;
  logic [7:0]  w_byte_cnt_nxt;
  logic [7:0]  w_gap_nxt;
  logic        w_gap_timeout;

  // Two-bit subtraction wraps naturally, giving (now - prev) mod 4.
  assign w_dibit        = phase_in - r_prev_phase;
  assign w_shift_nxt    = {r_shift[13:0], w_dibit};
  assign w_sync_cnt_nxt = (r_sync_cnt == 4'd8) ? 4'd8 : r_sync_cnt + 4'd1;
  assign w_sync_match   = (w_sync_cnt_nxt == 4'd8) && (w_shift_nxt == SYNC_WORD);
  assign w_byte_nxt     = {r_byte_asm, w_dibit};
  assign w_byte_cnt_nxt = r_byte_cnt + 8'd1;
  assign w_gap_nxt      = r_gap_cnt + 8'd1;
  assign w_gap_timeout  = !phase_valid && (w_gap_nxt == LP_GAP_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_prev_phase  <= 2'd0;
      r_shift       <= 16'd0;
      r_sync_cnt    <= 4'd0;
      r_byte_asm    <= 6'd0;
      r_dibit_idx   <= 2'd0;
      r_byte_cnt    <= 8'd0;
      r_gap_cnt     <= 8'd0;
      r_byte_out    <= 8'd0;
      r_byte_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_byte_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_gap_cnt <= 8'd0;
          // First symbol after idle only establishes the phase reference.
          if (phase_valid) begin
            r_prev_phase <= phase_in;
            r_shift      <= 16'd0;
            r_sync_cnt   <= 4'd0;
            r_state      <= ST_HUNT;
          end
        end

        ST_HUNT: begin
          if (!phase_valid) begin
            if (w_gap_timeout) begin
              r_gap_cnt <= 8'd0;
              r_state   <= ST_IDLE;
            end else begin
              r_gap_cnt <= w_gap_nxt;
            end
          end else begin
            r_gap_cnt    <= 8'd0;
            r_prev_phase <= phase_in;
            r_shift      <= w_shift_nxt;
            r_sync_cnt   <= w_sync_cnt_nxt;
            if (w_sync_match) begin
              r_frame_start <= 1'b1;
              r_locked      <= 1'b1;
              r_byte_asm    <= 6'd0;
              r_dibit_idx   <= 2'd0;
              r_byte_cnt    <= 8'd0;
              r_state       <= ST_PAYLOAD;
            end
          end
        end

        ST_PAYLOAD: begin
          if (!phase_valid) begin
            if (w_gap_timeout) begin
              r_frame_error <= 1'b1;
              r_locked      <= 1'b0;
              r_gap_cnt     <= 8'd0;
              r_byte_asm    <= 6'd0;
              r_dibit_idx   <= 2'd0;
              r_byte_cnt    <= 8'd0;
              r_state       <= ST_IDLE;
            end else begin
              r_gap_cnt <= w_gap_nxt;
            end
          end else begin
            r_gap_cnt    <= 8'd0;
            r_prev_phase <= phase_in;
            r_byte_asm   <= w_byte_nxt[5:0];
            r_dibit_idx  <= r_dibit_idx + 2'd1;
            if (r_dibit_idx == 2'd3) begin
              r_byte_out   <= w_byte_nxt;
              r_byte_valid <= 1'b1;
              r_byte_cnt   <= w_byte_cnt_nxt;
              // Frame complete: back to hunting with the phase reference kept.
              if (w_byte_cnt_nxt == LP_PAYLOAD_BYTES) begin
                r_frame_done <= 1'b1;
                r_locked     <= 1'b0;
                r_shift      <= 16'd0;
                r_sync_cnt   <= 4'd0;
                r_state      <= ST_HUNT;
              end
            end
          end
        end

        default: begin
          r_locked <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign byte_out    = r_byte_out;
  assign byte_valid  = r_byte_valid;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign frame_error = r_frame_error;
  assign locked      = r_locked;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_dqpsk_demodulator.sv
// Directed bench for dqpsk_demodulator: table of per-cycle vectors plus an
// asynchronous-reset sequence, with a byte scoreboard queue.
module tb_dqpsk_demodulator;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HUNT = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;

  typedef struct {
    logic [1:0] ph;
    logic       v;
    logic       ev;
    logic [7:0] eb;
    logic       fs;
    logic       fd;
    logic       fe;
    logic       lk;
    logic [1:0] st;
  } vec_t;

  logic       clock;
  logic       rst_n;
  logic [1:0] phase_in;
  logic       phase_valid;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       frame_start;
  logic       frame_done;
  logic       frame_error;
  logic       locked;
  logic [1:0] dbg_state;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_hold;
  int         checks;
  int         errors;

  dqpsk_demodulator #(
    .SYNC_WORD    (16'hE4E4),
    .PAYLOAD_BYTES(2),
    .GAP_MAX      (4)
  ) dut (
    .clock      (clock),
    .reset      (rst_n),
    .phase_in   (phase_in),
    .phase_valid(phase_valid),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .frame_error(frame_error),
    .locked     (locked),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] ph, input logic v, input logic ev, input logic [7:0] eb,
                     input logic fs, input logic fd, input logic fe, input logic lk,
                     input logic [1:0] st);
    vec_t r;
    r.ph = ph; r.v = v; r.ev = ev; r.eb = eb;
    r.fs = fs; r.fd = fd; r.fe = fe; r.lk = lk; r.st = st;
    vecs.push_back(r);
    if (ev) exp_q.push_back(eb);
  endtask

  // Shorthands: quiet symbol in HUNT / PAYLOAD, idle cycle in a given state.
  task automatic h(input logic [1:0] ph);
    add(ph, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, S_HUNT);
  endtask
  task automatic p(input logic [1:0] ph);
    add(ph, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, S_PAY);
  endtask
  task automatic sync_hit(input logic [1:0] ph);
    add(ph, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, S_PAY);
  endtask
  task automatic byte_mid(input logic [1:0] ph, input logic [7:0] b);
    add(ph, 1'b1, 1'b1, b, 1'b0, 1'b0, 1'b0, 1'b1, S_PAY);
  endtask
  task automatic byte_last(input logic [1:0] ph, input logic [7:0] b);
    add(ph, 1'b1, 1'b1, b, 1'b0, 1'b1, 1'b0, 1'b0, S_HUNT);
  endtask

  // Driver: apply one vector between edges, check #1 after the edge.
  task automatic run_row(input vec_t r, input int idx);
    @(negedge clock);
    phase_in    = r.ph;
    phase_valid = r.v;
    @(posedge clock);
    #1;
    if (r.ev) exp_hold = r.eb;
    chk($sformatf("row%0d byte_valid", idx), 32'(byte_valid), 32'(r.ev));
    chk($sformatf("row%0d frame_start", idx), 32'(frame_start), 32'(r.fs));
    chk($sformatf("row%0d frame_done", idx), 32'(frame_done), 32'(r.fd));
    chk($sformatf("row%0d frame_error", idx), 32'(frame_error), 32'(r.fe));
    chk($sformatf("row%0d locked", idx), 32'(locked), 32'(r.lk));
    chk($sformatf("row%0d state", idx), 32'(dbg_state), 32'(r.st));
    chk($sformatf("row%0d byte_out", idx), 32'(byte_out), 32'(exp_hold));
  endtask

  task automatic run_all(input int base);
    for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], base + i);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " byte_out"}, 32'(byte_out), 32'h0);
    chk({tag, " byte_valid"}, 32'(byte_valid), 32'h0);
    chk({tag, " frame_start"}, 32'(frame_start), 32'h0);
    chk({tag, " frame_done"}, 32'(frame_done), 32'h0);
    chk({tag, " frame_error"}, 32'(frame_error), 32'h0);
    chk({tag, " locked"}, 32'(locked), 32'h0);
    chk({tag, " state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  // Scoreboard: every delivered byte must be the next expected one.
  always @(negedge clock) begin
    if (rst_n && byte_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_byte: got unexpected byte %0h, expected none", byte_out);
      end else begin
        chk("sb_byte", 32'(byte_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    exp_hold    = 8'h00;
    rst_n       = 1'b0;
    phase_in    = 2'd0;
    phase_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_all_zero("reset");
    @(negedge clock);
    rst_n = 1'b1;

    // Reference, then sync 3,2,1,0,3,2,1,0; payload 0x63, then 1,1,1,1 -> 0x55.
    h(0);
    h(3); h(1); h(2); h(2); h(1); h(3); h(0); sync_hit(0);
    p(1); p(3); p(3); byte_mid(2, 8'h63);
    p(3); p(0); p(1); byte_last(2, 8'h55);
    // Re-sync from retained prev=2 without a new reference; constant phase -> 0x00.
    h(1); h(3); h(0); h(0); h(3); h(1); h(2); sync_hit(2);
    p(2); p(2); p(2); byte_mid(2, 8'h00);
    p(1); p(3); p(0); byte_last(0, 8'hE4);
    // Payload carrying the sync word itself: no re-sync, bytes delivered.
    h(3); h(1); h(2); h(2); h(1); h(3); h(0); sync_hit(0);
    p(3); p(1); p(2); byte_mid(2, 8'hE4);
    p(1); p(3); p(0); byte_last(0, 8'hE4);
    // Silent timeout in HUNT after 4 idle cycles.
    add(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, S_HUNT);
    add(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, S_HUNT);
    add(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, S_HUNT);
    add(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE);
    // New reference, then 7 sync dibits and a wrong 8th (dibit 1).
    h(0);
    h(3); h(1); h(2); h(2); h(1); h(3); h(0); h(1);
    // Genuine sync from prev=1.
    h(0); h(2); h(3); h(3); h(2); h(0); h(1); sync_hit(1);
    // Gap abort after 2 payload dibits.
    p(2); p(3);
    add(3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, S_PAY);
    add(3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, S_PAY);
    add(3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, S_PAY);
    add(3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, S_IDLE);
    // Reference 0 must be taken; sync from 0 then matches on the 8th dibit.
    h(0);
    h(3); h(1); h(2); h(2); h(1); h(3); h(0); sync_hit(0);
    p(1); p(2);
    run_all(0);

    // Asynchronous reset between edges while locked.
    #2;
    rst_n = 1'b0;
    #1;
    exp_hold = 8'h00;
    chk_all_zero("async_reset");
    @(negedge clock);
    rst_n       = 1'b1;
    phase_valid = 1'b0;
    vecs.delete();
    h(2);
    h(1); h(3); h(0); h(0); h(3); h(1); h(2); sync_hit(2);
    run_all(1000);

    @(negedge clock);
    phase_valid = 1'b0;
    @(negedge clock);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
